fifo_wptr_gray: RTL
===================

# fifo_wptr_gray

Write-side pointer block for the dual-clock FIFO: the producer of the Gray-coded pointer that the read domain synchronizes and decodes. It maintains the binary write pointer, publishes a registered Gray-coded copy for CDC, decodes the synchronized read-domain Gray pointer back to binary for occupancy, and generates a registered full flag and ready/valid write handshake. It sits entirely in the write clock domain, between the producer interface and the FIFO storage write port.

## Interface
- width_p, default 5: pointer width; address width is width_p-1, depth is 2^(width_p-1); width_p >= 2.
- clk_i  in  1  write-domain clock.
- reset_i  in  1  reset; asynchronous, active-high.
- valid_i  in  1  producer has a word to write.
- ready_o  out  1  block accepts a write; equals ~full_o.
- rptr_gray_sync_i  in  width_p  read pointer in Gray code, already synchronized into clk_i domain.
- wen_o  out  1  storage write enable; valid_i & ready_o (combinational).
- waddr_o  out  width_p-1  storage write address; low width_p-1 bits of binary write pointer.
- wptr_gray_o  out  width_p  registered Gray write pointer, for the read-domain synchronizer.
- full_o  out  1  registered full flag.
- count_o  out  width_p  occupancy seen from the write side, 0..2^(width_p-1).

## Operation
- State: wptr_bin_r (width_p), wptr_gray_r (width_p), full_r (1). All reset to 0 asynchronously; full_o=0, ready_o=1, wptr_gray_o=0, waddr_o=0, count_o=0 (with rptr_gray_sync_i=0) during and after reset.
- Write fire = valid_i & ~full_r. On fire: wptr_bin_next = wptr_bin_r + 1 (mod 2^width_p); otherwise hold.
- wptr_gray_next = wptr_bin_next ^ (wptr_bin_next >> 1); wptr_gray_r loads it every cycle. wptr_gray_o driven only from the register, never from combinational logic (CDC requirement).
- full_next = (wptr_gray_next == {~rptr_gray_sync_i[w-1], ~rptr_gray_sync_i[w-2], rptr_gray_sync_i[w-3:0]}); compared every cycle, so full also clears when the read pointer advances without a write.
- Write attempt while full_r=1: ignored; pointers unchanged; wen_o=0.
- Read pointer decode: rptr_bin = Gray-to-binary of rptr_gray_sync_i (MSB passes through, each lower bit = next-higher binary bit XOR Gray bit).
- count_o = wptr_bin_r - rptr_bin, modulo 2^width_p; combinational from registers/input.
- Wrap-around: wptr_bin_r rolls 2^width_p-1 -> 0; Gray rolls {1,0...0} -> 0 (single-bit change). waddr_o rolls 2^(width_p-1)-1 -> 0 at every half-period of the pointer.
- Full/count are pessimistic by synchronizer latency; block never overfills assuming rptr_gray_sync_i only moves forward.

## Timing
- Fire at edge N: waddr_o/wen_o valid in cycle before edge N (storage writes at edge N); wptr_gray_o and full_o update at edge N; visible cycle N+1.
- Latency valid_i to full_o assertion on the filling write: 1 cycle; ready_o drops same cycle as full_o.
- rptr_gray_sync_i change at cycle M: count_o changes in cycle M (combinational); full_o clears at edge M+1.
- Back-to-back writes: one per cycle, sustained, until full.
- reset_i asserted mid-operation: all registers clear immediately, not waiting for clk_i; first write after release uses waddr_o=0.
- Exactly one bit of wptr_gray_o changes per cycle that has a fire; zero bits otherwise.

## Test plan
- Reset: assert reset_i between edges with pointers nonzero -> wptr_gray_o=0, full_o=0, ready_o=1, count_o=0 before next edge.
- Fill (width_p=5, rptr_gray_sync_i=0): 16 consecutive fires -> waddr_o 0..15, after 16th edge full_o=1, ready_o=0, wptr_gray_o=5'b11000, count_o=16; 17th valid_i gives wen_o=0, pointers hold.
- Drain release: from full, set rptr_gray_sync_i=5'b00001 -> count_o=15 same cycle, full_o=0 and ready_o=1 one edge later; next fire gives waddr_o=0.
- Wrap: writes with rptr tracking 8 behind, 40 fires -> wptr_bin 31->0 with wptr_gray_o 5'b10000->5'b00000, waddr_o 15->0 twice, full_o never asserts.
- Gray property: 64 fires interleaved with random idle cycles -> Hamming distance between consecutive wptr_gray_o values is 1 on fire cycles, 0 otherwise; decoding wptr_gray_o equals a reference counter.
- Simultaneous: full, with valid_i=1 and rptr advancing by one in same cycle -> write rejected that cycle (full_r=1), accepted next cycle, full_o reasserts after that fire.

Source files
------------

// File: rtl/fifo_wptr_gray_if.sv
// Write-side bundle of the dual-clock FIFO pointer block: producer handshake,
// synchronized read pointer in, storage write port and CDC pointer out.
interface fifo_wptr_gray_if #(
    parameter int width_p = 5
);
    logic               valid_i;
    logic               ready_o;
    logic [width_p-1:0] rptr_gray_sync_i;
    logic               wen_o;
    logic [width_p-2:0] waddr_o;
    logic [width_p-1:0] wptr_gray_o;
    logic               full_o;
    logic [width_p-1:0] count_o;

    modport slave (
        input  valid_i, rptr_gray_sync_i,
        output ready_o, wen_o, waddr_o, wptr_gray_o, full_o, count_o
    );

    modport master (
        output valid_i, rptr_gray_sync_i,
        input  ready_o, wen_o, waddr_o, wptr_gray_o, full_o, count_o
    );
endinterface

// File: rtl/fifo_wptr_gray.sv
// Write-domain pointer of a dual-clock FIFO: binary write pointer, registered
// Gray copy for the read-domain synchronizer, registered full flag and occupancy.
module fifo_wptr_gray #(
    parameter int width_p = 5
) (
    input  logic              clk_i,
    input  logic              reset_i,
    fifo_wptr_gray_if.slave   wr_if
);
    // Full when the Gray pointers differ in exactly the top two bits.
    localparam logic [width_p-1:0] FullMask = width_p'(3) << (width_p - 2);

    logic [width_p-1:0] wptr_bin_q, wptr_bin_d;
    logic [width_p-1:0] wptr_gray_q, wptr_gray_d;
    logic               full_q, full_d;
    logic [width_p-1:0] rptr_bin;
    logic               fire;

    assign fire        = wr_if.valid_i & ~full_q;
    assign wptr_bin_d  = wptr_bin_q + width_p'(fire);
    assign wptr_gray_d = wptr_bin_d ^ (wptr_bin_d >> 1);
    assign full_d      = (wptr_gray_d == (wr_if.rptr_gray_sync_i ^ FullMask));

    // Each binary bit is the XOR of all Gray bits at and above it.
    always_comb begin
        rptr_bin = '0;
        for (int i = 0; i < width_p; i++) begin
            rptr_bin[i] = ^(wr_if.rptr_gray_sync_i >> i);
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wptr_bin_q  <= '0;
            wptr_gray_q <= '0;
            full_q      <= 1'b0;
        end else begin
            wptr_bin_q  <= wptr_bin_d;
            wptr_gray_q <= wptr_gray_d;
            full_q      <= full_d;
        end
    end

    assign wr_if.ready_o     = ~full_q;
    assign wr_if.wen_o       = fire;
    assign wr_if.waddr_o     = wptr_bin_q[width_p-2:0];
    assign wr_if.wptr_gray_o = wptr_gray_q;
    assign wr_if.full_o      = full_q;
    assign wr_if.count_o     = wptr_bin_q - rptr_bin;
endmodule
